// File: rtl/round_sequencer.sv
// round_sequencer: play-mode sequencer for the binary game.
// Each round it loads an LFSR target, counts the round timer down, scores
// the player's Submit, and tracks the best score since reset.
module round_sequencer #(
    parameter int           NUM_ROUNDS = 10,
    parameter int           TICK_DIV   = 100000000,
    parameter int           ROUND_TIME = 9,
    parameter logic [7:0]   LFSR_SEED  = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       CEN,
    input  logic       Start,
    input  logic       Submit,
    input  logic       Quit,
    input  logic [7:0] userNumber,
    output logic [7:0] targetNumber,
    output logic [3:0] timeLeft,
    output logic [3:0] roundCount,
    output logic [7:0] score,
    output logic [7:0] highScore,
    output logic       lastHit,
    output logic       q_Idle,
    output logic       q_Load,
    output logic       q_Wait,
    output logic       q_Check,
    output logic       q_Done
);
    localparam int         TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0] RT        = 4'(ROUND_TIME);
    localparam logic [3:0] NR        = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, DONE} state_t;
    state_t state, state_nx;

    logic [7:0]    lfsr;
    logic [TW-1:0] tick;
    logic          hit;

    // Qualified button events; quit outranks submit, submit outranks start.
    logic st, sb, qt, go;
    assign st = CEN & Start;
    assign sb = CEN & Submit;
    assign qt = CEN & Quit;
    assign go = st & ~sb & ~qt;

    logic       wrap, timeout;
    logic [3:0] rc_nx;
    logic [8:0] sum;
    logic [7:0] sum_sat;
    assign wrap    = (tick == TICK_LAST);
    assign timeout = wrap && (timeLeft == 4'd0);
    assign rc_nx   = roundCount + 4'd1;
    assign sum     = {1'b0, score} + {5'b0, timeLeft} + 9'd1;
    assign sum_sat = sum[8] ? 8'hFF : sum[7:0];

    // Free-running Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1; non-zero seed keeps it off 0.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = LOAD;
            LOAD:    state_nx = qt ? IDLE : WAIT;
            WAIT: begin
                if (qt)                 state_nx = IDLE;
                else if (sb || timeout) state_nx = CHECK;
            end
            CHECK:   state_nx = (rc_nx == NR) ? DONE : LOAD;
            DONE: begin
                if (qt)      state_nx = IDLE;
                else if (go) state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Round datapath: target load, timer, hit capture, scoring and high score.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            targetNumber <= 8'd0;
            timeLeft     <= 4'd0;
            roundCount   <= 4'd0;
            score        <= 8'd0;
            highScore    <= 8'd0;
            lastHit      <= 1'b0;
            hit          <= 1'b0;
            tick         <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    score      <= 8'd0;
                    roundCount <= 4'd0;
                    lastHit    <= 1'b0;
                end
                LOAD: begin
                    targetNumber <= lfsr;
                    timeLeft     <= RT;
                    tick         <= '0;
                end
                WAIT: if (!qt) begin
                    tick <= wrap ? '0 : tick + 1'b1;
                    // A submit on the timeout edge still gets compared.
                    if (sb)                       hit <= (userNumber == targetNumber);
                    else if (timeout)             hit <= 1'b0;
                    else if (wrap)                timeLeft <= timeLeft - 4'd1;
                end
                CHECK: begin
                    if (hit) score <= sum_sat;
                    lastHit    <= hit;
                    roundCount <= rc_nx;
                end
                DONE: begin
                    // Score is frozen in DONE, so this resolves on the first DONE edge.
                    if (score > highScore) highScore <= score;
                    if (!qt && go) begin
                        score      <= 8'd0;
                        roundCount <= 4'd0;
                        lastHit    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q_Idle  = (state == IDLE);
    assign q_Load  = (state == LOAD);
    assign q_Wait  = (state == WAIT);
    assign q_Check = (state == CHECK);
    assign q_Done  = (state == DONE);
endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Sequences the play mode of the binary game, one round after another.
- Each round it picks an 8-bit target from a free-running LFSR and runs a per-round countdown timer.
- It compares the player's switch value on Submit, keeps the score and round count, and tracks the high score across games.
- Sits beside binary_game in game_top. Button inputs are qualified by the shared single-cycle CEN pulse. Outputs drive the SSD/VGA muxes.

Parameters:
- NUM_ROUNDS, 10, rounds per game (1..15)
- TICK_DIV, 100000000, Clk cycles per timer tick (1 s at 100 MHz)
- ROUND_TIME, 9, timer start value in ticks per round (1..15)
- LFSR_SEED, 8'hA5, LFSR reset value (must be non-zero)

Ports:
- Clk  in  1  system clock; all state updates on posedge
- Reset  in  1  asynchronous, active-low reset
- CEN  in  1  single-cycle enable, high for one clock on any debounced button press
- Start  in  1  start/restart request, acted on only when CEN=1
- Submit  in  1  submit current guess, acted on only when CEN=1
- Quit  in  1  abort/exit, acted on only when CEN=1
- userNumber  in  8  player's switch value
- targetNumber  out  8  current round's target
- timeLeft  out  4  remaining ticks in the round
- roundCount  out  4  rounds completed this game
- score  out  8  current game score, saturating
- highScore  out  8  best score since reset
- lastHit  out  1  1 if the previous round was answered correctly
- q_Idle, q_Load, q_Wait, q_Check, q_Done  out  1 each  one-hot state flags

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE; targetNumber=0, timeLeft=0, roundCount=0, score=0, highScore=0, lastHit=0.
  - LFSR=LFSR_SEED; tick counter=0.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Shifts every Clk in every state.
  - Never reaches 0. Sampled only in LOAD.
- Qualified events: st=CEN&Start, sb=CEN&Submit, qt=CEN&Quit.
- Priority when asserted in the same cycle: qt > sb > st.
- IDLE:
  - st -> LOAD, with score=0, roundCount=0, lastHit=0 in the same edge.
  - Anything else: stay.
- LOAD (exactly 1 cycle):
  - targetNumber<=LFSR, timeLeft<=ROUND_TIME, tick counter<=0.
  - -> WAIT, or -> IDLE if qt.
- WAIT:
  - Tick counter counts 0..TICK_DIV-1 and wraps.
  - On wrap with timeLeft>0: timeLeft decrements.
  - On wrap with timeLeft==0: timeout. hit<=0, -> CHECK.
  - sb: hit<=(userNumber==targetNumber), -> CHECK.
  - sb in the same cycle as timeout: sb wins, userNumber is compared.
  - qt -> IDLE; score, roundCount, targetNumber are held and highScore is not updated.
  - st is ignored.
- CHECK (exactly 1 cycle):
  - If hit: score<=min(255, score+timeLeft+1).
  - lastHit<=hit; roundCount<=roundCount+1.
  - If the new roundCount==NUM_ROUNDS -> DONE, else -> LOAD.
  - qt is ignored in CHECK.
- DONE:
  - On the entry edge: highScore<=score if score>highScore.
  - Then: st -> LOAD (new game, score/roundCount cleared as in IDLE); qt -> IDLE.
  - Outputs are held.
- Latency:
  - sb in WAIT at edge n: q_Check high after edge n.
  - score, roundCount, lastHit update at edge n+1, together with q_Load or q_Done.
  - highScore updates at edge n+2.
- Widths and saturation:
  - Score arithmetic is 9-bit internally, clamped to 8'hFF.
  - roundCount never exceeds NUM_ROUNDS.
  - The tick counter is sized $clog2(TICK_DIV).
- State flags are exactly one-hot at all times after reset.
- Reset asserted mid-round: immediate return to reset values, including highScore.

Test Plan:
- TICK_DIV=4, ROUND_TIME=3, NUM_ROUNDS=2, reset then st -> q_Load for 1 cycle, then q_Wait; targetNumber=first LFSR step from 8'hA5 (model-checked); timeLeft=3.
- In WAIT set userNumber=targetNumber, sb immediately -> q_Check 1 cycle; score=4, lastHit=1, roundCount=1, q_Load next.
- Wrong guess in round 2 -> score stays 4, lastHit=0, roundCount=2, q_Done; highScore=4 one cycle later; st restarts with score=0, highScore=4.
- No submit: timeLeft 3->2->1->0 every 4 cycles; timeout 4 cycles after reaching 0 -> CHECK with hit=0; timeout coincident with a correct sb -> scored +1.
- qt and sb in the same WAIT cycle -> IDLE, score unchanged, highScore unchanged; sb/qt/st with CEN=0 -> no state change.
- Score saturation: force score=254, correct hit with timeLeft=3 -> score=255. Reset pulse mid-WAIT -> all outputs 0, q_Idle=1, LFSR back to 8'hA5.
